// File: rtl/knight_pkg.sv
// rtl/knight_pkg.sv - shared encodings and helpers for the knight-rider speed scheduler
//
// Purpose : scheduler state encodings, the LED home pattern that marks a sweep
//           boundary, and the divisor clamp used for PS-requested values.
// Ports   : none (package).
package knight_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_MANUAL    = 3'd0,
        S_RAMP_DN   = 3'd1,
        S_HOLD_FAST = 3'd2,
        S_RAMP_UP   = 3'd3,
        S_HOLD_SLOW = 3'd4
    } state_t;

    // The sweep starts (and restarts) from the rightmost LED.
    localparam logic [3:0] LED_HOME = 4'b0001;

    function automatic logic [31:0] clamp_cdiv(input logic [31:0] v,
                                               input logic [31:0] lo,
                                               input logic [31:0] hi);
        logic [31:0] r;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/knight_sched_if.sv
// rtl/knight_sched_if.sv - PS request/acknowledge port of the speed scheduler
//
// Purpose : groups the PS-side divisor load handshake.
// Signals : PS_REQ  - request, held until PS_ACK
//           PS_CDIV - requested divisor, sampled when PS_ACK is generated
//           PS_ACK  - one-cycle acceptance pulse
// Modports: master = PS requester, slave = scheduler.
interface knight_sched_if;

    logic        PS_REQ;
    logic [31:0] PS_CDIV;
    logic        PS_ACK;

    modport master (output PS_REQ, output PS_CDIV, input  PS_ACK);
    modport slave  (input  PS_REQ, input  PS_CDIV, output PS_ACK);

endinterface

// File: rtl/knight_bnd_det.sv
// rtl/knight_bnd_det.sv - sweep boundary detector
//
// Purpose : pulses bnd for the first cycle the sweep LED shows the home pattern.
// Ports   : clk    - clock
//           rst_n  - asynchronous active-low reset
//           led_in - LED output of the sweep datapath
//           bnd    - one-cycle boundary pulse (combinational from led_in)
module knight_bnd_det
    import knight_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] led_in,
    output logic       bnd
);

    logic [3:0] led_q;
    logic [3:0] led_d;

    always_comb begin
        led_d = led_in;
    end

    // Resetting to the home pattern suppresses a false boundary right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= LED_HOME;
        end else begin
            led_q <= led_d;
        end
    end

    assign bnd = (led_in == LED_HOME) && (led_q != LED_HOME);

endmodule

// File: rtl/knight_sched.sv
// rtl/knight_sched.sv - knight-rider sweep speed scheduler
//
// Purpose : owns the sweep divisor; runs an accelerate/hold/decelerate profile
//           or loads PS-requested values, changing the divisor only on sweep
//           boundaries.
// Ports   : CLK     - clock
//           RESETN  - asynchronous active-low reset
//           LED_IN  - LED output of the sweep datapath
//           AUTO_EN - 1 = automatic profile, 0 = PS owns the divisor
//           ps      - PS request/acknowledge port (slave side)
//           CDIV    - registered divisor to the sweep datapath
//           STATE   - current scheduler state
//           PEND    - accepted PS value waiting for a boundary
module knight_sched
    import knight_pkg::*;
#(
    parameter logic [31:0] CDIV_MIN    = 32'd2_500_000,
    parameter logic [31:0] CDIV_MAX    = 32'd25_000_000,
    parameter logic [31:0] CDIV_STEP   = 32'd2_500_000,
    parameter int          HOLD_SWEEPS = 4
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic [3:0]          LED_IN,
    input  logic                AUTO_EN,
    knight_sched_if.slave       ps,
    output logic [31:0]         CDIV,
    output logic [STATE_W-1:0]  STATE,
    output logic                PEND
);

    localparam int HOLD_W = (HOLD_SWEEPS > 1) ? $clog2(HOLD_SWEEPS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_SWEEPS - 1);

    // Comparing against these edges, rather than computing cdiv -/+ step first,
    // keeps the ramp arithmetic from wrapping.
    localparam logic [31:0] DN_EDGE = CDIV_MIN + CDIV_STEP;
    localparam logic [31:0] UP_EDGE = CDIV_MAX - CDIV_STEP;

    state_t              state_q, state_d;
    logic [31:0]         cdiv_q, cdiv_d;
    logic [31:0]         pval_q, pval_d;
    logic                pend_q, pend_d;
    logic                ack_q, ack_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                bnd;
    logic                accept;

    knight_bnd_det u_bnd_det (
        .clk    (CLK),
        .rst_n  (RESETN),
        .led_in (LED_IN),
        .bnd    (bnd)
    );

    always_comb begin
        state_d = state_q;
        cdiv_d  = cdiv_q;
        pval_d  = pval_q;
        pend_d  = pend_q;
        hold_d  = hold_q;

        // ack_q in the term stops a held request from being taken twice.
        accept  = ps.PS_REQ && !AUTO_EN && !pend_q && !ack_q;
        ack_d   = accept;

        if (accept) begin
            pend_d = 1'b1;
            pval_d = clamp_cdiv(ps.PS_CDIV, CDIV_MIN, CDIV_MAX);
        end

        if (bnd) begin
            if (state_q == S_MANUAL) begin
                // A pending load wins over starting the ramp.
                if (pend_q) begin
                    cdiv_d = pval_q;
                    pend_d = 1'b0;
                end else if (AUTO_EN) begin
                    state_d = S_RAMP_DN;
                end
            end else if (!AUTO_EN) begin
                state_d = S_MANUAL;
            end else begin
                case (state_q)
                    S_RAMP_DN: begin
                        if (cdiv_q <= DN_EDGE) begin
                            cdiv_d  = CDIV_MIN;
                            hold_d  = '0;
                            state_d = S_HOLD_FAST;
                        end else begin
                            cdiv_d = cdiv_q - CDIV_STEP;
                        end
                    end
                    S_HOLD_FAST: begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = S_RAMP_UP;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                    S_RAMP_UP: begin
                        if (cdiv_q >= UP_EDGE) begin
                            cdiv_d  = CDIV_MAX;
                            hold_d  = '0;
                            state_d = S_HOLD_SLOW;
                        end else begin
                            cdiv_d = cdiv_q + CDIV_STEP;
                        end
                    end
                    S_HOLD_SLOW: begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = S_RAMP_DN;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = S_MANUAL;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= S_MANUAL;
            cdiv_q  <= CDIV_MAX;
            pval_q  <= CDIV_MAX;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cdiv_q  <= cdiv_d;
            pval_q  <= pval_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            hold_q  <= hold_d;
        end
    end

    assign CDIV      = cdiv_q;
    assign STATE     = state_q;
    assign PEND      = pend_q;
    assign ps.PS_ACK = ack_q;

endmodule

// File: tb/tb_knight_sched.sv
// tb/tb_knight_sched.sv - self-checking bench for knight_sched
module tb_knight_sched;
    import knight_pkg::*;

    localparam logic [31:0] P_MIN  = 32'd2;
    localparam logic [31:0] P_MAX  = 32'd10;
    localparam logic [31:0] P_STEP = 32'd3;
    localparam int          P_HOLD = 2;

    localparam longint L_MIN  = 2;
    localparam longint L_MAX  = 10;
    localparam longint L_STEP = 3;

    localparam int M_MANUAL = 0, M_DN = 1, M_HFAST = 2, M_UP = 3, M_HSLOW = 4;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic [3:0]  led_in = 4'b0001;
    logic        auto_en = 1'b0;
    logic [31:0] cdiv;
    logic [2:0]  state;
    logic        pend;

    knight_sched_if ps_if ();

    knight_sched #(
        .CDIV_MIN    (P_MIN),
        .CDIV_MAX    (P_MAX),
        .CDIV_STEP   (P_STEP),
        .HOLD_SWEEPS (P_HOLD)
    ) dut (
        .CLK     (CLK),
        .RESETN  (RESETN),
        .LED_IN  (led_in),
        .AUTO_EN (auto_en),
        .ps      (ps_if),
        .CDIV    (cdiv),
        .STATE   (state),
        .PEND    (pend)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int bnd_seen = 0;
    int ack_seen = 0;

    typedef struct {
        int          cyc;
        logic [31:0] cdiv;
        int          mode;
        bit          pend;
    } bexp_t;

    bexp_t bq[$];
    int    aq[$];
    int    obs_cdiv[$];
    int    obs_state[$];
    bit    rec_en = 1'b0;

    logic [31:0] last_cdiv = P_MAX;
    logic [31:0] last_state = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm, input string what);
        n_chk++;
        n_err++;
        $display("FAIL %s: %s (t=%0t)", nm, what, $time);
    endtask

    // ---------------- reference model ----------------
    int          m_mode;
    longint      m_cdiv;
    int          m_hold;
    bit          m_pend;
    longint      m_pval;
    bit          m_ack;
    logic [3:0]  m_led_prev;
    bit          m_bnd;
    bit          m_acc;
    bexp_t       m_e;

    function automatic longint clampv(input longint v);
        if (v < L_MIN) return L_MIN;
        if (v > L_MAX) return L_MAX;
        return v;
    endfunction

    always @(posedge CLK) begin
        cyc++;
        if (!RESETN) begin
            m_mode = M_MANUAL; m_cdiv = L_MAX; m_hold = 0;
            m_pend = 1'b0; m_pval = L_MAX; m_ack = 1'b0; m_led_prev = 4'b0001;
        end else begin
            m_bnd = (led_in == 4'b0001) && (m_led_prev != 4'b0001);
            m_acc = ps_if.PS_REQ && !auto_en && !m_pend && !m_ack;
            if (m_bnd) begin
                if (m_mode == M_MANUAL) begin
                    if (m_pend) begin
                        m_cdiv = m_pval;
                        m_pend = 1'b0;
                    end else if (auto_en) begin
                        m_mode = M_DN;
                    end
                end else if (!auto_en) begin
                    m_mode = M_MANUAL;
                end else begin
                    case (m_mode)
                        M_DN: begin
                            if (m_cdiv - L_STEP <= L_MIN) begin
                                m_cdiv = L_MIN; m_mode = M_HFAST; m_hold = 0;
                            end else m_cdiv = m_cdiv - L_STEP;
                        end
                        M_HFAST: begin
                            m_hold++;
                            if (m_hold >= P_HOLD) m_mode = M_UP;
                        end
                        M_UP: begin
                            if (m_cdiv + L_STEP >= L_MAX) begin
                                m_cdiv = L_MAX; m_mode = M_HSLOW; m_hold = 0;
                            end else m_cdiv = m_cdiv + L_STEP;
                        end
                        default: begin
                            m_hold++;
                            if (m_hold >= P_HOLD) m_mode = M_DN;
                        end
                    endcase
                end
            end
            if (m_acc) begin
                m_pend = 1'b1;
                m_pval = clampv(longint'(ps_if.PS_CDIV));
                aq.push_back(cyc);
            end
            m_ack = m_acc;
            if (m_bnd) begin
                m_e.cyc = cyc; m_e.cdiv = 32'(m_cdiv); m_e.mode = m_mode; m_e.pend = m_pend;
                bq.push_back(m_e);
            end
            m_led_prev = led_in;
        end
    end

    // ---------------- monitor ----------------
    bexp_t mon_e;
    int    mon_a;

    always @(negedge CLK) begin
        if (!RESETN) begin
            bq.delete();
            aq.delete();
            last_cdiv  = P_MAX;
            last_state = 32'd0;
        end else begin
            if (bq.size() > 0 && bq[0].cyc == cyc) begin
                mon_e = bq.pop_front();
                chk("bnd_cdiv", cdiv, mon_e.cdiv);
                chk("bnd_state", 32'(state), 32'(mon_e.mode));
                chk("bnd_pend", 32'(pend), 32'(mon_e.pend));
                last_cdiv  = mon_e.cdiv;
                last_state = 32'(mon_e.mode);
                bnd_seen++;
                if (rec_en) begin
                    obs_cdiv.push_back(int'(cdiv));
                    obs_state.push_back(int'(state));
                end
            end else begin
                chk("stable_cdiv", cdiv, last_cdiv);
                chk("stable_state", 32'(state), last_state);
            end
            if (ps_if.PS_ACK) begin
                ack_seen++;
                if (aq.size() == 0) begin
                    fail_now("ack_unexpected", "got PS_ACK=1, required 0");
                end else begin
                    mon_a = aq.pop_front();
                    chk("ack_cycle", 32'(cyc), 32'(mon_a));
                end
            end else if (aq.size() > 0 && aq[0] < cyc) begin
                fail_now("ack_missing", "got PS_ACK=0, required 1");
                void'(aq.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    int   sw_idx = 0;
    int   sw_left = 1;
    logic [3:0] tick_prev;
    bit   home_edge = 1'b0;

    function automatic logic [3:0] pat(input int i);
        case (i)
            0: return 4'b0001;
            1: return 4'b0010;
            2: return 4'b0100;
            3: return 4'b1000;
            4: return 4'b0100;
            default: return 4'b0010;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
        if (ps_if.PS_ACK) ps_if.PS_REQ = 1'b0;
        tick_prev = led_in;
        if (sw_left > 1) begin
            sw_left--;
        end else begin
            sw_idx  = (sw_idx + 1) % 6;
            sw_left = int'($urandom_range(1, 2));
            led_in  = pat(sw_idx);
        end
        home_edge = (led_in == 4'b0001) && (tick_prev != 4'b0001);
    endtask

    task automatic request(input logic [31:0] v);
        ps_if.PS_CDIV = v;
        ps_if.PS_REQ  = 1'b1;
    endtask

    task automatic wait_ack();
        int k = 0;
        while (!ps_if.PS_ACK && k < 200) begin
            tick();
            k++;
        end
        if (!ps_if.PS_ACK) fail_now("ack_timeout", "got no PS_ACK, required one");
    endtask

    task automatic wait_bnd_count(input int target);
        int k = 0;
        while (bnd_seen < target && k < 400) begin
            tick();
            k++;
        end
        if (bnd_seen < target) fail_now("bnd_timeout", "boundary not reached in cycle budget");
    endtask

    task automatic wait_bnds(input int n);
        wait_bnd_count(bnd_seen + n);
    endtask

    logic [31:0] cdiv_b;
    int          a_before;
    int          b0;
    int          k;
    logic [31:0] rv;
    int          exp_c[12] = '{10, 7, 4, 2, 2, 2, 5, 8, 10, 10, 10, 7};
    int          exp_s[12] = '{1, 1, 1, 2, 2, 3, 3, 3, 4, 4, 1, 1};

    initial begin
        ps_if.PS_REQ  = 1'b0;
        ps_if.PS_CDIV = 32'd0;
        tick();
        tick();
        RESETN = 1'b1;

        // 1: reset values, nothing moves across boundaries in manual
        chk("rst_cdiv", cdiv, 32'd10);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ack", 32'(ps_if.PS_ACK), 32'd0);
        chk("rst_pend", 32'(pend), 32'd0);
        wait_bnds(3);
        chk("idle_cdiv", cdiv, 32'd10);
        chk("idle_state", 32'(state), 32'd0);

        // 2: auto profile
        auto_en = 1'b1;
        rec_en  = 1'b1;
        wait_bnd_count(bnd_seen + 12);
        rec_en  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i < obs_cdiv.size()) begin
                chk("profile_cdiv", 32'(obs_cdiv[i]), 32'(exp_c[i]));
                chk("profile_state", 32'(obs_state[i]), 32'(exp_s[i]));
            end
        end

        // 3: PS load with clamping
        auto_en = 1'b0;
        wait_bnds(1);
        request(32'd50);
        wait_ack();
        chk("load_pend_set", 32'(pend), 32'd1);
        wait_bnds(1);
        chk("clamp_hi_cdiv", cdiv, 32'd10);
        chk("clamp_hi_pend", 32'(pend), 32'd0);
        request(32'd0);
        wait_ack();
        wait_bnds(1);
        chk("clamp_zero_cdiv", cdiv, 32'd2);

        // 4: arbitration
        auto_en = 1'b1;
        wait_bnds(2);
        request(32'd7);
        a_before = ack_seen;
        repeat (20) tick();
        chk("no_ack_in_auto", 32'(ack_seen), 32'(a_before));
        auto_en = 1'b0;
        tick();
        chk("ack_after_auto_off", 32'(ps_if.PS_ACK), 32'd1);
        cdiv_b = cdiv;
        wait_bnds(1);
        chk("manual_state", 32'(state), 32'd0);
        chk("manual_cdiv_kept", cdiv, cdiv_b);

        // 5: accept on a boundary cycle, second request while pending
        wait_bnds(2);
        k = 0;
        tick();
        while (!home_edge && k < 60) begin
            tick();
            k++;
        end
        request(32'd9);
        cdiv_b = cdiv;
        wait_ack();
        b0 = bnd_seen;
        chk("bnd_accept_pend", 32'(pend), 32'd1);
        tick();
        request(32'd4);
        wait_bnd_count(b0 + 1);
        chk("bnd_accept_cdiv_kept", cdiv, cdiv_b);
        wait_bnd_count(b0 + 2);
        chk("bnd_accept_applied", cdiv, 32'd9);
        wait_ack();
        wait_bnds(1);
        chk("second_req_applied", cdiv, 32'd4);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
            if (!ps_if.PS_REQ && $urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 3))
                    0: rv = 32'd0;
                    1: rv = 32'($urandom_range(0, 12));
                    2: rv = $urandom;
                    default: rv = 32'hFFFF_FFFF;
                endcase
                request(rv);
            end
        end
        auto_en = 1'b0;
        k = 0;
        while (ps_if.PS_REQ && k < 500) begin
            tick();
            k++;
        end
        if (ps_if.PS_REQ) fail_now("drain_timeout", "request still outstanding");

        // 6: asynchronous reset mid ramp-up with a pending value
        auto_en = 1'b1;
        k = 0;
        while (state != 3'd3 && k < 500) begin
            tick();
            k++;
        end
        chk("reached_ramp_up", 32'(state), 32'd3);
        auto_en = 1'b0;
        request(32'd5);
        k = 0;
        while (!pend && k < 10) begin
            tick();
            k++;
        end
        chk("pend_before_reset", 32'(pend), 32'd1);
        @(negedge CLK);
        #2;
        RESETN = 1'b0;
        ps_if.PS_REQ = 1'b0;
        #1;
        chk("async_rst_cdiv", cdiv, 32'd10);
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_ack", 32'(ps_if.PS_ACK), 32'd0);
        chk("async_rst_pend", 32'(pend), 32'd0);
        tick();
        tick();
        RESETN = 1'b1;
        wait_bnds(4);
        chk("post_rst_cdiv", cdiv, 32'd10);

        @(negedge CLK);
        #1;
        chk("bnd_queue_drained", 32'(bq.size()), 32'd0);
        chk("ack_queue_drained", 32'(aq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/knight_sched.md
# knight_sched

Speed scheduler for the knight-rider LED sweep. It owns the `CDIV` divisor input of the sweep datapath and watches the sweep's `LED` output to find sweep boundaries. It arbitrates divisor ownership between an automatic accelerate/hold/decelerate profile and a PS-side request/acknowledge port. Every divisor change lands on a sweep boundary, so the visible speed never changes mid-sweep.

## Interface
Parameters:
- `CDIV_MIN`, default 32'd2_500_000: fastest divisor; floor for the ramp and for clamping.
- `CDIV_MAX`, default 32'd25_000_000: slowest divisor; ceiling for the ramp and for clamping. This is the reset value.
- `CDIV_STEP`, default 32'd2_500_000: change applied per sweep while ramping.
- `HOLD_SWEEPS`, default 4: number of sweeps spent at each extreme. Must be ≥ 1.

Ports:
- `CLK`  in  1: clock. Single clock domain.
- `RESETN`  in  1: reset, asynchronous, active-low.
- `LED_IN`  in  4: `LED` output of the sweep datapath.
- `AUTO_EN`  in  1: level. 1 selects the automatic profile; 0 gives ownership to the PS.
- `PS_REQ`  in  1: PS request to load `PS_CDIV`. Held until `PS_ACK`.
- `PS_CDIV`  in  32: requested divisor. Sampled in the cycle `PS_ACK` is generated.
- `PS_ACK`  out  1: one-cycle acceptance pulse.
- `CDIV`  out  32: divisor driven to the sweep datapath. Registered.
- `STATE`  out  3: current scheduler state, for debug and readback.
- `PEND`  out  1: an accepted PS value is waiting for a boundary.

## Operation

**Sweep boundary**
- `BND` = (`LED_IN` == 4'b0001) && (`led_q` != 4'b0001).
- `led_q` is `LED_IN` registered. It resets to 4'b0001, so there is no boundary right after reset.

**States.** Encodings: `S_MANUAL`=0, `S_RAMP_DN`=1, `S_HOLD_FAST`=2, `S_RAMP_UP`=3, `S_HOLD_SLOW`=4. All transitions and all `CDIV` updates happen only in `BND` cycles.

- **`S_MANUAL`**
  - If `PEND`: `CDIV` ← pending value and `PEND` clears. The state stays `S_MANUAL`.
  - Otherwise, if `AUTO_EN`=1: go to `S_RAMP_DN` and leave `CDIV` unchanged.
- **`S_RAMP_DN`**
  - If `CDIV` ≤ `CDIV_MIN`+`CDIV_STEP`: `CDIV` ← `CDIV_MIN`, `hold_cnt` ← 0, go to `S_HOLD_FAST`.
  - Otherwise: `CDIV` ← `CDIV` − `CDIV_STEP`.
  - This comparison form guarantees the subtraction never underflows.
- **`S_HOLD_FAST`**
  - If `hold_cnt` == `HOLD_SWEEPS`−1: go to `S_RAMP_UP`.
  - Otherwise: `hold_cnt` increments.
- **`S_RAMP_UP`**
  - If `CDIV` ≥ `CDIV_MAX`−`CDIV_STEP`: `CDIV` ← `CDIV_MAX`, `hold_cnt` ← 0, go to `S_HOLD_SLOW`.
  - Otherwise: `CDIV` ← `CDIV` + `CDIV_STEP`.
- **`S_HOLD_SLOW`**: same as `S_HOLD_FAST`, but exits to `S_RAMP_DN`.
- **`AUTO_EN`=0 in any auto state**: at the next `BND`, go to `S_MANUAL` and keep `CDIV`. This takes priority over the state's normal action.

**PS handshake**
- Accept when `PS_REQ`=1, `AUTO_EN`=1'b0, `PEND`=0 and `PS_ACK`=0.
- On the next edge:
  - `PS_ACK` ← 1 for exactly one cycle.
  - Pending value ← clamp(`PS_CDIV`, `CDIV_MIN`, `CDIV_MAX`).
  - `PEND` ← 1.
- While `AUTO_EN`=1 or `PEND`=1, `PS_REQ` waits with `PS_ACK`=0.
- The requester drops `PS_REQ` in the cycle after it sees `PS_ACK`.

**Arithmetic and widths**
- All arithmetic is 32-bit unsigned.
- `PS_CDIV` = 0 clamps to `CDIV_MIN`.
- `hold_cnt` is wide enough for `HOLD_SWEEPS`−1.

## Timing
**Reset values**
- `CDIV`=`CDIV_MAX`, `STATE`=`S_MANUAL`.
- `PS_ACK`=0, `PEND`=0, `hold_cnt`=0, `led_q`=4'b0001.
- Reset is asynchronous: asserting it mid-ramp or mid-handshake clears immediately. Any pending value is discarded and `PS_ACK` drops.

**Latencies**
- `CDIV` updates at the clock edge that ends the first cycle in which `LED_IN` shows 0001. The datapath therefore uses the new divisor for the whole of that sweep.
- `PS_ACK` rises 1 cycle after an acceptable `PS_REQ`.

**Simultaneous events**
- Accept and `BND` in the same cycle: the value becomes pending at that edge. It is applied at the following `BND`, not the current one.
- `BND` with `PEND`=1: the value is applied and `PEND` clears. A waiting `PS_REQ` can be accepted from the next cycle on.
- `AUTO_EN` rising while `PEND`=1: the pending value is still applied first in `S_MANUAL`. The ramp starts at the `BND` after that.

**Other**
- Non-`BND` cycles never change `CDIV` or `STATE`.

## Structure
- Shared package `knight_pkg`:
  - State encodings `S_*` and the state width (3).
  - The LED home pattern 4'b0001.
- Sub-module `knight_bnd_det`: holds the `led_q` register and produces the one-cycle `BND` pulse.
- The scheduler FSM, the pending register and the handshake live in `knight_sched`.

## Test plan
Parameters for all scenarios: `CDIV_MIN`=2, `CDIV_MAX`=10, `CDIV_STEP`=3, `HOLD_SWEEPS`=2. The sweep model drives `LED_IN`.

1. **Reset**: release `RESETN`, `AUTO_EN`=0 → `CDIV`=10, `STATE`=0, `PS_ACK`=0, `PEND`=0, and no change across 3 boundaries.
2. **Auto profile**: `AUTO_EN`=1 → the boundary sequence must be:
   - `CDIV`: 10 (enter `S_RAMP_DN`), 7, 4, 2.
   - `S_HOLD_FAST` for 2 boundaries, then 5, 8, 10.
   - `S_HOLD_SLOW` for 2 boundaries, then 7.
3. **PS load and clamp**: `AUTO_EN`=0, `PS_REQ` with `PS_CDIV`=50 → `PS_ACK` pulse 1 cycle later, `PEND`=1. At the next `BND`, `CDIV`=10 and `PEND`=0. Repeat with `PS_CDIV`=0 → `CDIV`=2.
4. **Arbitration**: `AUTO_EN`=1 and `PS_REQ` held → `PS_ACK` stays 0. Drop `AUTO_EN` → state `S_MANUAL` at the next `BND`, with `CDIV` unchanged. `PS_ACK` asserts one cycle after `AUTO_EN`=0.
5. **Simultaneous events**: accept in a `BND` cycle → `CDIV` is unchanged at that boundary and takes the value at the next one. A second `PS_REQ` while `PEND`=1 is not acknowledged until after the apply.
6. **Mid-operation reset**: assert `RESETN`=0 mid-`S_RAMP_UP` with `PEND`=1 → outputs take their reset values asynchronously, with no clock edge needed.
